// File: rtl/shift_issue_stage.sv
// Issue stage feeding the 16-bit combinational barrel shifter. Decoded shift micro-ops
// are resolved, buffered in a 2-entry FIFO and presented from a stall-stable output register.
module shift_issue_stage #(
  parameter int DW   = 16,
  parameter int SAW  = 4,
  parameter int TAGW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [DW-1:0]   in_rt,
  input  logic [DW-1:0]   in_rs,
  input  logic [SAW-1:0]  in_shamt,
  input  logic [TAGW-1:0] in_tag,
  output logic [DW-1:0]   d,
  output logic [SAW-1:0]  sa,
  output logic            right,
  output logic            arith,
  output logic            out_valid,
  output logic [TAGW-1:0] out_tag,
  input  logic            out_ready,
  output logic            illegal_op,
  output logic [15:0]     issue_count
);

  localparam int EW = DW + SAW + 2 + TAGW;

  logic [EW-1:0]  mem [2];
  logic           wptr;
  logic           rptr;
  logic [1:0]     count;

  logic           legal;
  logic           accept;
  logic           push;
  logic           load_en;
  logic           pop;
  logic [SAW-1:0] sa_res;
  logic [EW-1:0]  entry;
  logic           unused_rs;

  assign unused_rs = ^in_rs[DW-1:SAW];

  always_comb begin
    legal   = ~(in_op[1] & in_op[0]);
    load_en = ~out_valid | out_ready;
    pop     = load_en && (count != 2'd0);
    // A full FIFO may still accept when its head is leaving in the same cycle.
    in_ready = (count != 2'd2) || pop;
    accept  = in_valid && in_ready;
    push    = accept && legal;
    sa_res  = in_op[2] ? in_rs[SAW-1:0] : in_shamt;
    entry   = {in_rt, sa_res, in_op[0] | in_op[1], in_op[1], in_tag};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      count       <= '0;
      out_valid   <= 1'b0;
      d           <= '0;
      sa          <= '0;
      right       <= 1'b0;
      arith       <= 1'b0;
      out_tag     <= '0;
      illegal_op  <= 1'b0;
      issue_count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= entry;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      if (load_en) begin
        out_valid <= (count != 2'd0);
        if (count != 2'd0) {d, sa, right, arith, out_tag} <= mem[rptr];
      end

      illegal_op <= accept && !legal;
      if (out_valid && out_ready) issue_count <= issue_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: latency, decode, backpressure, illegal ops,
// mid-flight reset and issue counter wrap, checked with immediate assertions.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_rt;
  logic [15:0] in_rs;
  logic [3:0]  in_shamt;
  logic [2:0]  in_tag;
  logic [15:0] d;
  logic [3:0]  sa;
  logic        right;
  logic        arith;
  logic        out_valid;
  logic [2:0]  out_tag;
  logic        out_ready;
  logic        illegal_op;
  logic [15:0] issue_count;

  int checks   = 0;
  int failures = 0;

  shift_issue_stage #(.DW(16), .SAW(4), .TAGW(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rt(in_rt), .in_rs(in_rs), .in_shamt(in_shamt), .in_tag(in_tag),
    .d(d), .sa(sa), .right(right), .arith(arith),
    .out_valid(out_valid), .out_tag(out_tag), .out_ready(out_ready),
    .illegal_op(illegal_op), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] rt, input logic [15:0] rs,
                       input logic [3:0] shamt, input logic [2:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_rt    = rt;
    in_rs    = rs;
    in_shamt = shamt;
    in_tag   = tag;
  endtask

  function automatic logic [15:0] shf(input logic [15:0] x, input logic [3:0] s,
                                      input logic r, input logic a);
    if (!r) return x << s;
    if (a)  return 16'($signed(x) >>> s);
    return x >> s;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rt = '0; in_rs = '0;
    in_shamt = '0; in_tag = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_count", 32'(issue_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_illegal", 32'(illegal_op), 32'd0);

    // SLL rt=1 shamt=4: two cycles to output
    drive(3'b000, 16'h0001, 16'h0000, 4'd4, 3'd5);
    tick(); in_valid = 1'b0;
    chk("sll_lat1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("sll_valid", 32'(out_valid), 32'd1);
    chk("sll_d", 32'(d), 32'h0001);
    chk("sll_sa", 32'(sa), 32'd4);
    chk("sll_ra", 32'({right, arith}), 32'd0);
    chk("sll_tag", 32'(out_tag), 32'd5);
    chk("sll_shift", 32'(shf(d, sa, right, arith)), 32'h0010);
    tick();
    chk("sll_drain_valid", 32'(out_valid), 32'd0);
    chk("sll_count", 32'(issue_count), 32'd1);

    // SRAV rt=8000 rs=0013
    drive(3'b110, 16'h8000, 16'h0013, 4'd0, 3'd2);
    tick(); in_valid = 1'b0;
    tick();
    chk("srav_valid", 32'(out_valid), 32'd1);
    chk("srav_sa", 32'(sa), 32'd3);
    chk("srav_ra", 32'({right, arith}), 32'b11);
    chk("srav_shift", 32'(shf(d, sa, right, arith)), 32'hF000);
    tick();
    chk("srav_count", 32'(issue_count), 32'd2);

    // Backpressure: four ops with out_ready low
    out_ready = 1'b0;
    drive(3'b001, 16'h1234, 16'h0000, 4'd1, 3'd1);
    tick();
    drive(3'b100, 16'h00FF, 16'h0007, 4'd0, 3'd3);
    tick();
    chk("bp_a_valid", 32'(out_valid), 32'd1);
    chk("bp_a_d", 32'(d), 32'h1234);
    drive(3'b010, 16'h8001, 16'h0000, 4'd15, 3'd4);
    tick();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    drive(3'b101, 16'hF0F0, 16'h1234, 4'd0, 3'd6);
    tick();
    chk("bp_full_ready2", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_d", 32'(d), 32'h1234);
    chk("bp_hold_sa", 32'(sa), 32'd1);
    chk("bp_hold_ra", 32'({right, arith}), 32'b10);
    chk("bp_hold_tag", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_pop_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    chk("bp_b_d", 32'(d), 32'h00FF);
    chk("bp_b_sa", 32'(sa), 32'd7);
    chk("bp_b_tag", 32'(out_tag), 32'd3);
    tick();
    chk("bp_c_d", 32'(d), 32'h8001);
    chk("bp_c_ra", 32'({right, arith}), 32'b11);
    chk("bp_c_sa", 32'(sa), 32'd15);
    tick();
    chk("bp_d_d", 32'(d), 32'hF0F0);
    chk("bp_d_sa", 32'(sa), 32'd4);
    chk("bp_d_tag", 32'(out_tag), 32'd6);
    tick();
    chk("bp_drain_valid", 32'(out_valid), 32'd0);
    chk("bp_count", 32'(issue_count), 32'd6);

    // Illegal op 011
    drive(3'b011, 16'hAAAA, 16'h0000, 4'd2, 3'd7);
    chk("ill_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    chk("ill_valid0", 32'(out_valid), 32'd0);
    tick();
    chk("ill_pulse_end", 32'(illegal_op), 32'd0);
    chk("ill_valid1", 32'(out_valid), 32'd0);
    tick();
    chk("ill_valid2", 32'(out_valid), 32'd0);
    chk("ill_count", 32'(issue_count), 32'd6);
    drive(3'b111, 16'h5555, 16'h0000, 4'd1, 3'd0);
    tick(); in_valid = 1'b0;
    chk("ill7_pulse", 32'(illegal_op), 32'd1);
    tick(); tick();
    chk("ill7_valid", 32'(out_valid), 32'd0);

    // Reset with three ops in flight
    out_ready = 1'b0;
    drive(3'b000, 16'h0101, 16'h0000, 4'd1, 3'd1); tick();
    drive(3'b001, 16'h0202, 16'h0000, 4'd2, 3'd2); tick();
    drive(3'b010, 16'h0303, 16'h0000, 4'd3, 3'd3); tick();
    in_valid = 1'b0;
    chk("mid_full_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_count", 32'(issue_count), 32'd0);
    chk("mid_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_stale", 32'(out_valid), 32'd0);
    end
    chk("mid_count_after", 32'(issue_count), 32'd0);

    // Counter wrap under a sustained stream
    drive(3'b000, 16'h0001, 16'h0000, 4'd0, 3'd0);
    for (int i = 0; i < 70000; i++) begin
      if (issue_count == 16'hFFFF) break;
      tick();
    end
    chk("wrap_ffff", 32'(issue_count), 32'hFFFF);
    chk("wrap_streaming", 32'(out_valid), 32'd1);
    tick();
    chk("wrap_zero", 32'(issue_count), 32'h0000);
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
